serial_subtractor: RTL

Bit-serial unsigned subtractor computing diff = a - b (mod 2^WIDTH) and borrow = (a < b). Operands are processed LSB first, one bit per clock, through a single full-subtractor cell with a registered borrow flip-flop. It is the subtraction counterpart to the team's ripple full-adder datapath. It sits behind a valid/ready input handshake and in front of a valid/ready output handshake, for area-constrained arithmetic paths.

---
 rtl/serial_subtractor.sv | 110 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), borrow = (a < b).
// One full-subtractor cell with a registered borrow, LSB first, valid/ready on both sides.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic             bin_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] res_sh_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;
   logic             in_ready_q;
   logic             out_valid_q;

   logic             a_bit;
   logic             b_bit;
   logic             d_bit;
   logic             bout_d;
   logic [WIDTH-1:0] res_sh_d;

   always_comb begin
      a_bit    = a_sh_q[0];
      b_bit    = b_sh_q[0];
      d_bit    = a_bit ^ b_bit ^ bin_q;
      bout_d   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);
      res_sh_d = {d_bit, res_sh_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bin_q       <= 1'b0;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         res_sh_q    <= '0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               if (in_valid && in_ready_q) begin
                  a_sh_q     <= a;
                  b_sh_q     <= b;
                  bin_q      <= 1'b0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_sh_q   <= a_sh_q >> 1;
               b_sh_q   <= b_sh_q >> 1;
               res_sh_q <= res_sh_d;
               bin_q    <= bout_d;
               cnt_q    <= cnt_q + 1'b1;
               // last bit: publish the fully shifted result alongside the final borrow
               if (cnt_q == LAST_BIT) begin
                  diff_q      <= res_sh_d;
                  borrow_q    <= bout_d;
                  out_valid_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign borrow    = borrow_q;

endmodule
